// File: rtl/beep_tone_decoder.sv
// ---------------------------------------------------------------------------
// beep_tone_decoder
//
// Measures the period of an asynchronous square-wave tone on 'beep' and
// classifies it as one of the seven natural notes C4..B4.
//
// The beep input is brought into the clk domain through a two-flop
// synchronizer. A third flop holds the previous sample for rising-edge
// detection, and the edge pulse itself is registered. Between two rising
// edges a counter runs. On each edge its value becomes the measured period,
// which is compared against a +/-3 % band around each nominal note period.
// When no edge arrives within TIMEOUT_CYC cycles, the decoder drops back to
// IDLE and reports silence.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   PERIOD_W    width of the period counter and of the period output
//   TIMEOUT_CYC cycles without a rising edge before silence is declared
//               (must stay below 2**PERIOD_W - 1 so the counter can reach it)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   beep       asynchronous tone input
//   period     last accepted period in clk cycles
//   note       note code: 0 = unknown, 1..7 = C4..B4
//   note_valid one-cycle strobe when period/note update
//   silent     high while no tone is present
//
// Build option
//   BEEP_TONE_DECODER_FILTER_EN  when defined, a measurement is reported
//   only if its note code equals the code of the measurement just before it.
//   The first period after IDLE therefore never strobes.
// ---------------------------------------------------------------------------
module beep_tone_decoder #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned PERIOD_W    = 20,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                beep,
  output logic [PERIOD_W-1:0] period,
  output logic [2:0]          note,
  output logic                note_valid,
  output logic                silent
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [PERIOD_W-1:0] COUNT_ONE   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] COUNT_MAX   = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] TIMEOUT_VAL = PERIOD_W'(TIMEOUT_CYC);

  // Note frequencies in Hz, index 1..7 = C4..B4.
  function automatic int unsigned tone_hz(input int unsigned k);
    case (k)
      1:       tone_hz = 262;
      2:       tone_hz = 294;
      3:       tone_hz = 330;
      4:       tone_hz = 349;
      5:       tone_hz = 392;
      6:       tone_hz = 440;
      7:       tone_hz = 494;
      default: tone_hz = 1;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Input synchronizer and registered rising-edge pulse
  // -------------------------------------------------------------------------
  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;
  logic edge_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      sync1_reg <= beep;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      edge_reg  <= sync2_reg & ~sync3_reg;
    end
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t              state_reg;
  logic [PERIOD_W-1:0] count_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [2:0]          note_reg;
  logic                valid_reg;
  logic                silent_reg;

  // -------------------------------------------------------------------------
  // Classification of the current counter value
  // -------------------------------------------------------------------------
  logic [63:0] count_ext;
  logic [7:1]  band_hit;
  logic [2:0]  code_next;

  assign count_ext = 64'(count_reg);

  generate
    for (genvar gi = 1; gi <= 7; gi++) begin : g_band
      localparam logic [63:0] NOM = 64'(CLK_HZ / tone_hz(gi));
      localparam logic [63:0] LO  = (NOM * 64'd97) / 64'd100;
      localparam logic [63:0] HI  = (NOM * 64'd103) / 64'd100;
      assign band_hit[gi] = (count_ext >= LO) && (count_ext <= HI);
    end
  endgenerate

  // Bands of neighbouring notes may overlap at some clock rates; scanning
  // downward lets the lowest matching code overwrite any higher one.
  always_comb begin
    code_next = 3'd0;
    for (int k = 7; k >= 1; k--) begin
      if (band_hit[k]) begin
        code_next = 3'(k);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control qualifiers
  // -------------------------------------------------------------------------
  logic timeout;
  logic measure_edge;
  logic accept;

  // Timeout wins over a coincident edge; that edge then restarts measuring
  // as a pure reference edge.
  assign timeout      = (state_reg == MEASURE) && (count_reg >= TIMEOUT_VAL);
  assign measure_edge = (state_reg == MEASURE) && !timeout && edge_reg;

`ifdef BEEP_TONE_DECODER_FILTER_EN
  // Code of the previous measurement. prev_valid_reg low marks it invalid,
  // so no code (including 0) can match right after reset or IDLE.
  logic       prev_valid_reg;
  logic [2:0] prev_code_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid_reg <= 1'b0;
      prev_code_reg  <= 3'd0;
    end else if (timeout) begin
      prev_valid_reg <= 1'b0;
    end else if (measure_edge) begin
      prev_valid_reg <= 1'b1;
      prev_code_reg  <= code_next;
    end
  end

  assign accept = measure_edge && prev_valid_reg && (prev_code_reg == code_next);
`else
  assign accept = measure_edge;
`endif

  // -------------------------------------------------------------------------
  // Measurement FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= '0;
      note_reg   <= 3'd0;
      valid_reg  <= 1'b0;
      silent_reg <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The first edge only provides a time reference.
          if (edge_reg) begin
            state_reg <= MEASURE;
            count_reg <= COUNT_ONE;
          end else begin
            count_reg <= '0;
          end
        end

        MEASURE: begin
          if (timeout) begin
            silent_reg <= 1'b1;
            note_reg   <= 3'd0;
            if (edge_reg) begin
              // Timeout and edge together: IDLE is passed through and the edge
              // immediately starts a new reference.
              count_reg <= COUNT_ONE;
            end else begin
              state_reg <= IDLE;
              count_reg <= '0;
            end
          end else if (edge_reg) begin
            count_reg <= COUNT_ONE;
            if (accept) begin
              period_reg <= count_reg;
              note_reg   <= code_next;
              valid_reg  <= 1'b1;
              silent_reg <= 1'b0;
            end
          end else if (count_reg != COUNT_MAX) begin
            count_reg <= count_reg + COUNT_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign period     = period_reg;
  assign note       = note_reg;
  assign note_valid = valid_reg;
  assign silent     = silent_reg;

endmodule

// File: tb/tb_beep_tone_decoder.sv
// ---------------------------------------------------------------------------
// tb_beep_tone_decoder
//
// Directed bench for beep_tone_decoder at CLK_HZ = 1 MHz, TIMEOUT_CYC =
// 10_000, PERIOD_W = 20. Every beep rising edge is launched 1 ns after a
// clock edge, so an accepted measurement strobes exactly 4 clock edges after
// the rising edge that closes it. Expected codes are hand-derived from
// Nk = 1e6/fk and the +/-3 % band. Examples: N6 = 2272 gives 2203..2340,
// N5 = 2551 gives 2474..2627, N3 = 3030 gives 2939..3120, and N1 = 3816
// gives 3701..3930.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_beep_tone_decoder;

  localparam int unsigned CLK_HZ      = 1_000_000;
  localparam int unsigned PERIOD_W    = 20;
  localparam int unsigned TIMEOUT_CYC = 10_000;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                beep  = 1'b0;
  logic [PERIOD_W-1:0] period;
  logic [2:0]          note;
  logic                note_valid;
  logic                silent;

  beep_tone_decoder #(
    .CLK_HZ     (CLK_HZ),
    .PERIOD_W   (PERIOD_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .beep      (beep),
    .period    (period),
    .note      (note),
    .note_valid(note_valid),
    .silent    (silent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int notes_q[$];
  int periods_q[$];
  int cycs_q[$];
  int rises_q[$];
  int exp_notes[$];
  int exp_periods[$];
  int bad_silent = 0;
  int consec     = 0;
  logic prev_nv  = 1'b0;

  // Strobe logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (note_valid === 1'b1) begin
      notes_q.push_back(int'(note));
      periods_q.push_back(int'(period));
      cycs_q.push_back(cyc);
      $display("strobe cyc=%0d note=%0d period=%0d silent=%0b", cyc, note, period, silent);
      if (silent !== 1'b0) bad_silent++;
      if (prev_nv === 1'b1) consec++;
    end
    prev_nv = note_valid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_count"}, 64'(notes_q.size()), 64'(exp_notes.size()));
    foreach (exp_notes[i]) begin
      check($sformatf("%s_note%0d", tag, i),
            (i < notes_q.size()) ? 64'(notes_q[i]) : 64'(-1), 64'(exp_notes[i]));
      check($sformatf("%s_period%0d", tag, i),
            (i < periods_q.size()) ? 64'(periods_q[i]) : 64'(-1), 64'(exp_periods[i]));
    end
  endtask

  task automatic clear_obs();
    notes_q.delete();
    periods_q.delete();
    cycs_q.delete();
    rises_q.delete();
  endtask

  // One full period starting with a rising edge; call 1 ns after a clock edge.
  task automatic drive_period(input int p);
    rises_q.push_back(cyc);
    beep = 1'b1;
    repeat (p / 2) @(posedge clk);
    #1 beep = 1'b0;
    repeat (p - p / 2) @(posedge clk);
    #1;
  endtask

  // Final rising edge that closes the previous period, then return low.
  task automatic rise_tail();
    rises_q.push_back(cyc);
    beep = 1'b1;
    repeat (8) @(posedge clk);
    #1 beep = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_obs();
  endtask

  int first_exp;
  int target;

  initial begin
    // ---- reset held 5 cycles with beep toggling ----
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 beep = ~beep;
    end
    @(negedge clk);
    check("rst_silent", 64'(silent), 64'(1));
    check("rst_note", 64'(note), 64'(0));
    check("rst_period", 64'(period), 64'(0));
    check("rst_note_valid", 64'(note_valid), 64'(0));
    check("rst_no_strobe", 64'(notes_q.size()), 64'(0));
    @(posedge clk);
    #1 beep = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_obs();

    // ---- 440 Hz, five rising edges ----
    for (int i = 0; i < 5; i++) drive_period(2272);
`ifdef BEEP_TONE_DECODER_FILTER_EN
    exp_notes   = '{6, 6, 6};
    exp_periods = '{2272, 2272, 2272};
    first_exp   = rises_q[2] + 4;
`else
    exp_notes   = '{6, 6, 6, 6};
    exp_periods = '{2272, 2272, 2272, 2272};
    first_exp   = rises_q[1] + 4;
`endif
    check_strobes("tone440");
    check("tone440_first_cyc", (cycs_q.size() > 0) ? 64'(cycs_q[0]) : 64'(-1), 64'(first_exp));
    check("tone440_note", 64'(note), 64'(6));
    check("tone440_period", 64'(period), 64'(2272));
    check("tone440_silent", 64'(silent), 64'(0));

    // ---- silence: timeout 10_000 cycles after the last reload ----
    target = rises_q[4] + 4 + int'(TIMEOUT_CYC);
    while (cyc < target - 1) @(negedge clk);
    check("timeout_silent_before", 64'(silent), 64'(0));
    @(negedge clk);
    check("timeout_silent", 64'(silent), 64'(1));
    check("timeout_note", 64'(note), 64'(0));
    check("timeout_period_hold", 64'(period), 64'(2272));
    check("timeout_no_strobe", 64'(notes_q.size()), 64'(exp_notes.size()));
    @(posedge clk);
    #1;

    // ---- period 3000 (note 3) then 5000 (note 0) ----
    clear_obs();
    drive_period(3000);
    check("idle_silent_held", 64'(silent), 64'(1));
    drive_period(3000);
    drive_period(3000);
    drive_period(5000);
    rise_tail();
`ifdef BEEP_TONE_DECODER_FILTER_EN
    exp_notes   = '{3, 3};
    exp_periods = '{3000, 3000};
`else
    exp_notes   = '{3, 3, 3, 0};
    exp_periods = '{3000, 3000, 3000, 5000};
`endif
    check_strobes("tone3000_5000");
    check("tone3000_silent", 64'(silent), 64'(0));

    // ---- 262 Hz with a one-cycle reset mid-period ----
    drive_period(3816);
    beep = 1'b1;
    repeat (1908) @(posedge clk);
    #1 beep = 1'b0;
    repeat (954) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_period", 64'(period), 64'(0));
    check("midrst_note", 64'(note), 64'(0));
    check("midrst_silent", 64'(silent), 64'(1));
    check("midrst_note_valid", 64'(note_valid), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_obs();
    repeat (953) @(posedge clk);
    #1;
    drive_period(3816);
    check("midrst_ref_only", 64'(notes_q.size()), 64'(0));
    drive_period(3816);
    drive_period(3816);
`ifdef BEEP_TONE_DECODER_FILTER_EN
    exp_notes   = '{1};
    exp_periods = '{3816};
    first_exp   = rises_q[2] + 4;
`else
    exp_notes   = '{1, 1};
    exp_periods = '{3816, 3816};
    first_exp   = rises_q[1] + 4;
`endif
    check_strobes("tone262");
    check("tone262_first_cyc", (cycs_q.size() > 0) ? 64'(cycs_q[0]) : 64'(-1), 64'(first_exp));

    // ---- alternating 2272 / 2551 ----
    reset_pulse();
    drive_period(2272);
    drive_period(2551);
    drive_period(2272);
    drive_period(2551);
    rise_tail();
`ifdef BEEP_TONE_DECODER_FILTER_EN
    exp_notes.delete();
    exp_periods.delete();
`else
    exp_notes   = '{6, 5, 6, 5};
    exp_periods = '{2272, 2551, 2272, 2551};
`endif
    check_strobes("alternate");

    // ---- band boundaries of note 6: 2203 and 2340 inside, 2341 outside ----
    reset_pulse();
    drive_period(2203);
    drive_period(2203);
    drive_period(2340);
    drive_period(2341);
    rise_tail();
`ifdef BEEP_TONE_DECODER_FILTER_EN
    exp_notes   = '{6, 6};
    exp_periods = '{2203, 2340};
`else
    exp_notes   = '{6, 6, 6, 0};
    exp_periods = '{2203, 2203, 2340, 2341};
`endif
    check_strobes("boundary");

    // ---- global strobe properties ----
    check("strobe_with_silent", 64'(bad_silent), 64'(0));
    check("strobe_back_to_back", 64'(consec), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beep_tone_decoder.md
BEEP_TONE_DECODER -- requirements
Module: beep_tone_decoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter PERIOD_W, default 20, width of the period counter and the period output.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000, number of clk cycles without a rising edge before silence is declared; it SHALL be less than 2^PERIOD_W-1.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port beep, input, 1, asynchronous square-wave tone to decode.
REQ-007 SHALL have port period, output, PERIOD_W, last measured full period in clk cycles.
REQ-008 SHALL have port note, output, 3, classified note code (0 = unknown, 1..7 = C4..B4).
REQ-009 SHALL have port note_valid, output, 1, one-cycle strobe when period and note update.
REQ-010 SHALL have port silent, output, 1, level high while no tone is present.

Function
REQ-011 SHALL pass beep through a 2-flop synchronizer, then detect a rising edge against a third registered copy (edge cycle E).
REQ-012 SHALL implement states IDLE (no reference edge) and MEASURE (counting since the last edge).
REQ-013 In IDLE, an edge SHALL clear the counter to 1, enter MEASURE, and produce no strobe.
REQ-014 In MEASURE, the counter SHALL increment each cycle, saturating at 2^PERIOD_W-1.
REQ-015 In MEASURE, an edge SHALL latch the counter into the period candidate, reload the counter to 1, and stay in MEASURE.
REQ-016 The period, note and note_valid outputs SHALL be registered in cycle E+1; latency from the beep pin rising is 4 clk edges.
REQ-017 SHALL compute the nominal period Nk = CLK_HZ/fk by integer division, with f1..f7 = 262, 294, 330, 349, 392, 440, 494 Hz.
REQ-018 Classification SHALL give code k when Nk*97/100 <= period <= Nk*103/100, else 0; if bands overlap, the lowest k wins.
REQ-019 When the counter reaches TIMEOUT_CYC in MEASURE, the block SHALL enter IDLE, assert silent, and set note to 0; period holds its value and no strobe is issued.
REQ-020 If an edge and the timeout occur in the same cycle, the timeout SHALL be applied first and the edge treated as the IDLE first edge per REQ-013.
REQ-021 silent SHALL deassert in the same cycle as the first note_valid after IDLE.
REQ-022 note_valid SHALL be high for exactly one cycle per accepted measurement and never on two consecutive cycles.

Reset
REQ-023 While rst_n is low, the block SHALL hold: state IDLE, counter 0, synchronizer flops 0, period 0, note 0, note_valid 0, silent 1.
REQ-024 Asserting reset mid-measurement SHALL discard the partial count; after release, the first edge is a reference edge only.

Configuration
REQ-025 Macro BEEP_TONE_DECODER_FILTER_EN SHALL gate the consecutive-match filter.
REQ-026 With BEEP_TONE_DECODER_FILTER_EN defined, a measurement SHALL strobe only if its code equals the code of the immediately preceding measurement (the previous code is cleared to an invalid marker on reset and on IDLE), so the first period after IDLE never strobes.
REQ-027 Without BEEP_TONE_DECODER_FILTER_EN, every measurement per REQ-015 SHALL strobe, and the filter register SHALL be absent.

Verification (CLK_HZ = 1_000_000, TIMEOUT_CYC = 10_000, PERIOD_W = 20)
REQ-028 Reset: hold rst_n low 5 cycles with beep toggling -> silent = 1, note = 0, period = 0, no note_valid.
REQ-029 440 Hz square wave (period 2272 clk) for 5 periods -> period = 2272, note = 6; 4 strobes without the filter, 3 strobes with it, first strobe 4 clk after the second rising edge.
REQ-030 Period 3000 clk (about 333 Hz; N3 = 3030, band 2939..3120) -> note = 3; period 5000 clk (200 Hz) -> note = 0 with a strobe (unfiltered build).
REQ-031 Stop beep low after a tone -> silent rises exactly 10_000 clk after the last counter reload, note = 0, period holds 2272.
REQ-032 Pull rst_n low for 1 cycle mid-period of a 262 Hz tone -> outputs return to reset values; the next strobe arrives only after 2 post-reset edges (3 with the filter).
REQ-033 Alternate periods 2272/2551 (unfiltered) -> strobes alternate note 6/5; with the filter, no strobe.
